bcd_countdown_timer: RTL and testbench

Parametrised N-digit BCD countdown timer with an internal borrow chain. Generalises the single-digit borrow-chained digit timer into one clocked block with selectable digit count, synchronous load, start/stop control and a terminal-count flag. It sits between the game/lab control FSM, which issues load/start/stop, and the seven-segment display driver, which consumes `digit_count`.

---
 rtl/bcd_countdown_timer_pkg.sv | 19 +
 rtl/bcd_digit_cell.sv | 32 +++
 rtl/bcd_countdown_timer.sv | 138 +++++++++++++
 tb/tb_bcd_countdown_timer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and helpers for the BCD countdown timer.
// Optional feature macro: BCD_TIMER_AUTO_RELOAD_EN.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } timer_state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] n);
    return (n > BCD_MAX) ? BCD_MAX : n;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the countdown chain with borrow in/out.
// Loads win over borrows; a borrow into 0 wraps to 9.
module bcd_digit_cell
  import timer_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       borrow_in,
  output logic       borrow_out,
  output logic       is_zero,
  output logic [3:0] digit
);

  logic [3:0] r_digit;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_digit <= BCD_ZERO;
    end else if (load) begin
      r_digit <= load_val;
    end else if (borrow_in) begin
      r_digit <= (r_digit == BCD_ZERO) ? BCD_MAX : r_digit - 4'd1;
    end
  end

  assign is_zero    = (r_digit == BCD_ZERO);
  assign borrow_out = is_zero & borrow_in;
  assign digit      = r_digit;

endmodule

// File: rtl/bcd_countdown_timer.sv
// N-digit BCD countdown timer: control FSM, shadow reload, done pulse.
// Optional feature macro: BCD_TIMER_AUTO_RELOAD_EN.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int NUM_DIGITS = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    LOAD,
  input  logic [4*NUM_DIGITS-1:0] default_num,
  input  logic                    START,
  input  logic                    STOP,
  input  logic                    tick,
  output logic [4*NUM_DIGITS-1:0] digit_count,
  output logic                    running,
  output logic                    zero,
  output logic                    done
);

  timer_state_t r_state;
  timer_state_t w_state_nxt;

  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [4*NUM_DIGITS-1:0] w_clamped;
  logic [4*NUM_DIGITS-1:0] w_load_val;
  logic [NUM_DIGITS-1:0]   w_is_zero;
  logic [NUM_DIGITS:0]     w_chain;

  logic r_done;
  logic w_done_nxt;
  logic w_load;
  logic w_dec;
  logic w_zero;
  logic w_upper_zero;
  logic w_is_one;
  logic w_reload;
  logic w_unused_borrow;

  always_comb begin
    w_clamped = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_clamped[4*i +: 4] = bcd_clamp(default_num[4*i +: 4]);
    end
  end

  always_comb begin
    w_upper_zero = 1'b1;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      w_upper_zero = w_upper_zero & w_is_zero[i];
    end
  end

  assign w_zero   = &w_is_zero;
  assign w_is_one = w_upper_zero & (digit_count[3:0] == 4'd1);

`ifdef BCD_TIMER_AUTO_RELOAD_EN
  assign w_reload = (r_shadow != '0);
`else
  assign w_reload = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= IDLE;
      r_done   <= 1'b0;
      r_shadow <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (LOAD) begin
        r_shadow <= w_clamped;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_load_val  = w_clamped;
    w_dec       = 1'b0;
    if (LOAD) begin
      w_load      = 1'b1;
      w_state_nxt = IDLE;
    end else if (STOP) begin
      if (r_state == RUN) begin
        w_state_nxt = PAUSED;
      end
    end else if (START) begin
      if (r_state == IDLE || r_state == PAUSED) begin
        if (w_zero) begin
          w_state_nxt = DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = RUN;
        end
      end
    end else if (tick && r_state == RUN) begin
      if (w_is_one) begin
        // terminal tick: force the final value instead of borrowing
        w_done_nxt = 1'b1;
        w_load     = 1'b1;
        if (w_reload) begin
          w_load_val = r_shadow;
        end else begin
          w_load_val  = '0;
          w_state_nxt = DONE;
        end
      end else if (!w_zero) begin
        w_dec = 1'b1;
      end
    end
  end

  assign w_chain[0] = w_dec;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit_cell u_cell (
      .CLK        (CLK),
      .RST        (RST),
      .load       (w_load),
      .load_val   (w_load_val[4*g +: 4]),
      .borrow_in  (w_chain[g]),
      .borrow_out (w_chain[g+1]),
      .is_zero    (w_is_zero[g]),
      .digit      (digit_count[4*g +: 4])
    );
  end

  // the top digit's borrow can never fire: decrement is blocked at zero
  assign w_unused_borrow = w_chain[NUM_DIGITS];

  assign running = (r_state == RUN);
  assign zero    = w_zero;
  assign done    = r_done;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Randomized and directed bench for bcd_countdown_timer against an integer model.
// Honours BCD_TIMER_AUTO_RELOAD_EN for the expected terminal behaviour.
module tb_bcd_countdown_timer;

  localparam int N  = 2;
  localparam int W  = 4 * N;
  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;
  localparam int M_DONE   = 3;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         LOAD = 1'b0;
  logic [W-1:0] default_num = '0;
  logic         START = 1'b0;
  logic         STOP = 1'b0;
  logic         tick = 1'b0;
  logic [W-1:0] digit_count;
  logic         running;
  logic         zero;
  logic         done;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  int m_val    = 0;
  int m_shadow = 0;
  int m_st     = M_IDLE;
  bit m_done   = 1'b0;

  bcd_countdown_timer #(.NUM_DIGITS(N)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .LOAD        (LOAD),
    .default_num (default_num),
    .START       (START),
    .STOP        (STOP),
    .tick        (tick),
    .digit_count (digit_count),
    .running     (running),
    .zero        (zero),
    .done        (done)
  );

  always #5 CLK = ~CLK;

  function automatic int load_value(input logic [W-1:0] dn);
    int v = 0;
    int p = 1;
    for (int i = 0; i < N; i++) begin
      int nib = int'(dn[4*i +: 4]);
      if (nib > 9) nib = 9;
      v += nib * p;
      p *= 10;
    end
    return v;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge RST) begin
    m_val = 0;
    m_shadow = 0;
    m_st = M_IDLE;
    m_done = 1'b0;
  end

  always @(posedge CLK) begin
    if (!RST) begin
      m_done = 1'b0;
      if (LOAD) begin
        m_val = load_value(default_num);
        m_shadow = m_val;
        m_st = M_IDLE;
      end else if (STOP) begin
        if (m_st == M_RUN) m_st = M_PAUSED;
      end else if (START) begin
        if (m_st == M_IDLE || m_st == M_PAUSED) begin
          if (m_val == 0) begin
            m_st = M_DONE;
            m_done = 1'b1;
          end else begin
            m_st = M_RUN;
          end
        end
      end else if (tick && m_st == M_RUN && m_val > 0) begin
        m_val = m_val - 1;
        if (m_val == 0) begin
          m_done = 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
          if (m_shadow != 0) m_val = m_shadow;
          else m_st = M_DONE;
`else
          m_st = M_DONE;
`endif
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("digit_count", 32'(digit_count), 32'(to_bcd(m_val)));
      chk("running", 32'(running), 32'(m_st == M_RUN));
      chk("zero", 32'(zero), 32'(m_val == 0));
      chk("done", 32'(done), 32'(m_done));
    end
  end

  task automatic step(input bit ld, input logic [W-1:0] dn, input bit st,
                      input bit sp, input bit tk);
    LOAD = ld;
    default_num = dn;
    START = st;
    STOP = sp;
    tick = tk;
    @(posedge CLK);
    @(negedge CLK);
    LOAD = 1'b0;
    START = 1'b0;
    STOP = 1'b0;
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, 1);
  endtask

  task automatic pulse_reset();
    #1 RST = 1'b1;
    #1 RST = 1'b0;
  endtask

  initial begin
    #1 RST = 1'b1;
    #12 RST = 1'b0;
    @(negedge CLK);
    chk("rst_count", 32'(digit_count), 32'h00);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk_en = 1'b1;

    step(1, 8'h2F, 0, 0, 0);
    chk("load_clamp", 32'(digit_count), 32'h29);

    step(1, 8'h20, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    ticks(1);
    chk("ripple_19", 32'(digit_count), 32'h19);
    ticks(9);
    chk("ripple_10", 32'(digit_count), 32'h10);
    ticks(1);
    chk("ripple_09", 32'(digit_count), 32'h09);

`ifdef BCD_TIMER_AUTO_RELOAD_EN
    step(1, 8'h03, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    ticks(3);
    chk("reload_done", 32'(done), 32'd1);
    chk("reload_val", 32'(digit_count), 32'h03);
    chk("reload_run", 32'(running), 32'd1);
    ticks(1);
    chk("reload_next", 32'(digit_count), 32'h02);
    chk("reload_done_off", 32'(done), 32'd0);
`else
    step(1, 8'h02, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    ticks(2);
    chk("term_val", 32'(digit_count), 32'h00);
    chk("term_done", 32'(done), 32'd1);
    chk("term_running", 32'(running), 32'd0);
    ticks(1);
    chk("term_hold", 32'(digit_count), 32'h00);
    chk("term_done_once", 32'(done), 32'd0);
`endif

    step(1, 8'h00, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    chk("start_zero_done", 32'(done), 32'd1);
    chk("start_zero_run", 32'(running), 32'd0);

    step(1, 8'h05, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    ticks(1);
    chk("pause_04", 32'(digit_count), 32'h04);
    step(0, '0, 0, 1, 1);
    chk("pause_hold", 32'(digit_count), 32'h04);
    chk("pause_running", 32'(running), 32'd0);
    ticks(3);
    chk("pause_ticks", 32'(digit_count), 32'h04);
    step(0, '0, 1, 0, 0);
    ticks(1);
    chk("resume_03", 32'(digit_count), 32'h03);

    step(1, 8'h29, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    ticks(5);
    chk("midrun_24", 32'(digit_count), 32'h24);
    #1 RST = 1'b1;
    #1;
    chk("async_count", 32'(digit_count), 32'h00);
    chk("async_running", 32'(running), 32'd0);
    chk("async_zero", 32'(zero), 32'd1);
    #1 RST = 1'b0;
    @(negedge CLK);
    step(0, '0, 1, 0, 1);
    chk("rst_needs_load", 32'(digit_count), 32'h00);
    step(1, 8'h29, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    chk("restart_29", 32'(digit_count), 32'h29);
    ticks(1);
    chk("restart_28", 32'(digit_count), 32'h28);

    for (int c = 0; c < 4000; c++) begin
      logic [W-1:0] dn;
      bit ld;
      bit st;
      bit sp;
      bit tk;
      dn = W'($urandom);
      if ($urandom_range(0, 1) == 1) dn[7:4] = 4'h0;
      ld = ($urandom_range(0, 24) == 0);
      st = ($urandom_range(0, 5) == 0);
      sp = !st && ($urandom_range(0, 9) == 0);
      tk = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 399) == 0) pulse_reset();
      step(ld, dn, st, sp, tk);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
